// File: rtl/div_ctrl_4b_pkg.sv
// Shared definitions for the integer-division board controller.
//   WIDTH    : operand/result width (fixed at 4 for this board)
//   IDX_W    : width of the bit index used by the serial divider
//   state_e  : controller FSM states
//   SEL_*    : display-select encodings (num, den, quotient, remainder)
package div_pkg;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned IDX_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] SEL_NUM = 2'd0;
  localparam logic [1:0] SEL_DEN = 2'd1;
  localparam logic [1:0] SEL_COC = 2'd2;
  localparam logic [1:0] SEL_RES = 2'd3;

endpackage

// File: rtl/div_ctrl_4b_if.sv
// Button/display bundle between the board and the division controller.
//   btn_num, btn_den, btn_calc, btn_sel : debounced button levels
//   conta_num, conta_den                : operand counters
//   cociente, resto                     : last quotient / remainder
//   Sel                                 : display select
//   busy, div_zero                      : status flags
// Modports: master = board/bench side, slave = controller side.
interface div_ctrl_4b_if;
  import div_pkg::*;

  logic             btn_num;
  logic             btn_den;
  logic             btn_calc;
  logic             btn_sel;
  logic [WIDTH-1:0] conta_num;
  logic [WIDTH-1:0] conta_den;
  logic [WIDTH-1:0] cociente;
  logic [WIDTH-1:0] resto;
  logic [1:0]       Sel;
  logic             busy;
  logic             div_zero;

  modport master (
    output btn_num, btn_den, btn_calc, btn_sel,
    input  conta_num, conta_den, cociente, resto, Sel, busy, div_zero
  );

  modport slave (
    input  btn_num, btn_den, btn_calc, btn_sel,
    output conta_num, conta_den, cociente, resto, Sel, busy, div_zero
  );

endinterface

// File: rtl/div_ctrl_4b_edge_rise.sv
// Rising-edge detector for one debounced button level.
//   clk, rst_n : clock, asynchronous active-low reset
//   in         : button level
//   pulse      : one-cycle pulse when in is high and the previous sample was low
module edge_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic pulse
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  always_comb begin
    pulse = in & ~prev_q;
  end

endmodule

// File: rtl/div_ctrl_4b.sv
// Division board controller: edge-detects the four buttons, keeps the
// numerator/denominator counters, runs a serial restoring division and
// cycles the display select.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : button inputs and display/status outputs (slave side)
module div_ctrl_4b
  import div_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  div_ctrl_4b_if.slave    bus
);

  logic num_p, den_p, calc_p, sel_p;

  edge_rise u_edge_num  (.clk(clk), .rst_n(rst_n), .in(bus.btn_num),  .pulse(num_p));
  edge_rise u_edge_den  (.clk(clk), .rst_n(rst_n), .in(bus.btn_den),  .pulse(den_p));
  edge_rise u_edge_calc (.clk(clk), .rst_n(rst_n), .in(bus.btn_calc), .pulse(calc_p));
  edge_rise u_edge_sel  (.clk(clk), .rst_n(rst_n), .in(bus.btn_sel),  .pulse(sel_p));

  state_e           state_q, state_d;
  logic [WIDTH-1:0] conta_num_q, conta_num_d;
  logic [WIDTH-1:0] conta_den_q, conta_den_d;
  logic [WIDTH-1:0] cociente_q, cociente_d;
  logic [WIDTH-1:0] resto_q, resto_d;
  logic [1:0]       sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [IDX_W-1:0] i_q, i_d;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   d_ext;
  logic             r_ge;
  logic             cnt_ok;

  // Counters only move while idle and never in the same cycle a division is
  // requested, so the operands latched at the calc edge match the display.
  always_comb begin
    cnt_ok      = (state_q == IDLE) && !calc_p;
    conta_num_d = conta_num_q;
    conta_den_d = conta_den_q;
    if (cnt_ok && num_p) begin
      conta_num_d = conta_num_q + WIDTH'(1);
    end
    if (cnt_ok && den_p) begin
      conta_den_d = conta_den_q + WIDTH'(1);
    end
  end

  always_comb begin
    sel_d = sel_q;
    if (sel_p) begin
      sel_d = (sel_q == SEL_RES) ? SEL_NUM : sel_q + 2'd1;
    end
  end

  // One restoring step per DIV cycle, numerator bits consumed MSB first.
  always_comb begin
    r_shift = {r_q[WIDTH-1:0], n_q[i_q]};
    d_ext   = {1'b0, d_q};
    r_ge    = (r_shift >= d_ext);
  end

  always_comb begin
    state_d    = state_q;
    cociente_d = cociente_q;
    resto_d    = resto_q;
    busy_d     = busy_q;
    div_zero_d = div_zero_q;
    n_d        = n_q;
    d_d        = d_q;
    r_d        = r_q;
    q_d        = q_q;
    i_d        = i_q;
    case (state_q)
      IDLE: begin
        if (calc_p) begin
          if (conta_den_q == '0) begin
            div_zero_d = 1'b1;
            cociente_d = '1;
            resto_d    = conta_num_q;
          end else begin
            n_d     = conta_num_q;
            d_d     = conta_den_q;
            r_d     = '0;
            q_d     = '0;
            i_d     = IDX_W'(WIDTH - 1);
            busy_d  = 1'b1;
            state_d = DIV;
          end
        end
      end
      DIV: begin
        if (r_ge) begin
          r_d      = r_shift - d_ext;
          q_d[i_q] = 1'b1;
        end else begin
          r_d      = r_shift;
          q_d[i_q] = 1'b0;
        end
        if (i_q == '0) begin
          state_d = DONE;
        end else begin
          i_d = i_q - IDX_W'(1);
        end
      end
      DONE: begin
        cociente_d = q_q;
        resto_d    = r_q[WIDTH-1:0];
        div_zero_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      conta_num_q <= '0;
      conta_den_q <= '0;
      cociente_q  <= '0;
      resto_q     <= '0;
      sel_q       <= SEL_NUM;
      busy_q      <= 1'b0;
      div_zero_q  <= 1'b0;
      n_q         <= '0;
      d_q         <= '0;
      r_q         <= '0;
      q_q         <= '0;
      i_q         <= '0;
    end else begin
      state_q     <= state_d;
      conta_num_q <= conta_num_d;
      conta_den_q <= conta_den_d;
      cociente_q  <= cociente_d;
      resto_q     <= resto_d;
      sel_q       <= sel_d;
      busy_q      <= busy_d;
      div_zero_q  <= div_zero_d;
      n_q         <= n_d;
      d_q         <= d_d;
      r_q         <= r_d;
      q_q         <= q_d;
      i_q         <= i_d;
    end
  end

  always_comb begin
    bus.conta_num = conta_num_q;
    bus.conta_den = conta_den_q;
    bus.cociente  = cociente_q;
    bus.resto     = resto_q;
    bus.Sel       = sel_q;
    bus.busy      = busy_q;
    bus.div_zero  = div_zero_q;
  end

endmodule

// File: tb/tb_div_ctrl_4b.sv
// Scoreboard bench for div_ctrl_4b: stimulus pushes expected snapshots and
// division results into queues; a monitor on the falling edge pops and compares.
module tb_div_ctrl_4b;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_ctrl_4b_if bus();

  div_ctrl_4b dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [3:0]  num;
    logic [3:0]  den;
    logic [3:0]  coc;
    logic [3:0]  res;
    logic [1:0]  sel;
    logic        busy;
    logic        dz;
    int unsigned due;
  } snap_t;

  typedef struct {
    string      name;
    logic [3:0] coc;
    logic [3:0] res;
  } res_t;

  snap_t snap_q[$];
  res_t  res_q[$];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic done = 1'b0;

  // bench-side model of the visible outputs
  logic [3:0] cur_num = '0, cur_den = '0, cur_coc = '0, cur_res = '0;
  logic [1:0] cur_sel = '0;
  logic       cur_busy = 1'b0, cur_dz = 1'b0;

  // monitor state
  int    busy_cnt = 0;
  logic  busy_prev = 1'b0;
  snap_t s;
  res_t  r;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt  = 0;
        busy_prev = 1'b0;
      end else begin
        if (bus.busy === 1'b1) busy_cnt++;
        if (busy_prev && bus.busy !== 1'b1) begin
          checks++;
          if (res_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result: coc=%0h res=%0h with no division outstanding", bus.cociente, bus.resto);
          end else begin
            r = res_q.pop_front();
            if (bus.cociente !== r.coc || bus.resto !== r.res || bus.div_zero !== 1'b0 || busy_cnt != 5) begin
              errors++;
              $display("FAIL %s: coc=%0h res=%0h dz=%0b busy_cycles=%0d required coc=%0h res=%0h dz=0 busy_cycles=5",
                       r.name, bus.cociente, bus.resto, bus.div_zero, busy_cnt, r.coc, r.res);
            end
          end
          busy_cnt = 0;
        end
        busy_prev = bus.busy;
      end
      if (snap_q.size() > 0 && snap_q[0].due <= cyc) begin
        s = snap_q.pop_front();
        checks++;
        if (bus.conta_num !== s.num || bus.conta_den !== s.den || bus.cociente !== s.coc ||
            bus.resto !== s.res || bus.Sel !== s.sel || bus.busy !== s.busy || bus.div_zero !== s.dz) begin
          errors++;
          $display("FAIL %s: num=%0h den=%0h coc=%0h res=%0h sel=%0d busy=%0b dz=%0b required num=%0h den=%0h coc=%0h res=%0h sel=%0d busy=%0b dz=%0b",
                   s.name, bus.conta_num, bus.conta_den, bus.cociente, bus.resto, bus.Sel, bus.busy, bus.div_zero,
                   s.num, s.den, s.coc, s.res, s.sel, s.busy, s.dz);
        end
      end
      if (done) begin
        checks++;
        if (snap_q.size() != 0 || res_q.size() != 0) begin
          errors++;
          $display("FAIL drain: snapshots_left=%0d results_left=%0d required 0 and 0", snap_q.size(), res_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: bus.btn_num  = v;
      1: bus.btn_den  = v;
      2: bus.btn_calc = v;
      default: bus.btn_sel = v;
    endcase
  endtask

  // 0 num, 1 den, 2 calc, 3 sel; returns just after the edge that takes the pulse
  task automatic press(input int b);
    step();
    set_btn(b, 1'b1);
    step();
    set_btn(b, 1'b0);
  endtask

  task automatic snap(input string name);
    snap_t e;
    e.name = name; e.num = cur_num; e.den = cur_den; e.coc = cur_coc; e.res = cur_res;
    e.sel = cur_sel; e.busy = cur_busy; e.dz = cur_dz; e.due = cyc;
    snap_q.push_back(e);
  endtask

  task automatic press_num(input int n);
    for (int k = 0; k < n; k++) begin
      press(0);
      cur_num = cur_num + 4'd1;
    end
  endtask

  task automatic press_den(input int n);
    for (int k = 0; k < n; k++) begin
      press(1);
      cur_den = cur_den + 4'd1;
    end
  endtask

  task automatic press_sel(input int n);
    for (int k = 0; k < n; k++) begin
      press(3);
      cur_sel = cur_sel + 2'd1;
    end
  endtask

  task automatic set_ops(input logic [3:0] num, input logic [3:0] den);
    logic [3:0] dn, dd;
    dn = num - cur_num;
    dd = den - cur_den;
    press_num(int'(dn));
    press_den(int'(dd));
  endtask

  task automatic push_res(input string name, input logic [3:0] coc, input logic [3:0] res);
    res_t e;
    e.name = name; e.coc = coc; e.res = res;
    res_q.push_back(e);
  endtask

  task automatic do_div(input string name, input logic [3:0] coc, input logic [3:0] res);
    press(2);
    push_res(name, coc, res);
    cur_busy = 1'b1;
    snap({name, "_busy"});
    cur_busy = 1'b0;
    repeat (7) step();
    cur_coc = coc;
    cur_res = res;
    cur_dz  = 1'b0;
    snap({name, "_after"});
  endtask

  task automatic model_reset();
    cur_num = '0; cur_den = '0; cur_coc = '0; cur_res = '0;
    cur_sel = '0; cur_busy = 1'b0; cur_dz = 1'b0;
  endtask

  initial begin
    bus.btn_num = 1'b0; bus.btn_den = 1'b0; bus.btn_calc = 1'b0; bus.btn_sel = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();
    snap("reset");
    step();
    rst_n = 1'b1;
    step();

    // basic division 7/2
    press_num(7);
    press_den(2);
    snap("load_7_2");
    do_div("div_7_2", 4'd3, 4'd1);

    // divide by zero, then 9/4
    press_den(14);
    press_num(2);
    snap("load_9_0");
    press(2);
    cur_dz = 1'b1; cur_coc = 4'hF; cur_res = 4'd9;
    snap("div_zero");
    repeat (3) step();
    snap("div_zero_hold");
    press_den(4);
    do_div("div_9_4", 4'd2, 4'd1);

    // counter wrap and select
    press_num(7);
    snap("num_wrap_15_to_0");
    press_num(16);
    snap("num_16_pulses");
    press_sel(5);
    snap("sel_5_pulses");
    step();
    bus.btn_sel = 1'b1;
    repeat (20) step();
    bus.btn_sel = 1'b0;
    cur_sel = cur_sel + 2'd1;
    step();
    snap("sel_held");

    // division boundaries
    set_ops(4'd15, 4'd1);
    do_div("div_15_1", 4'd15, 4'd0);
    set_ops(4'd3, 4'd7);
    do_div("div_3_7", 4'd0, 4'd3);
    set_ops(4'd15, 4'd15);
    do_div("div_15_15", 4'd1, 4'd0);

    // buttons while busy: num/den/calc ignored, sel accepted
    set_ops(4'd7, 4'd2);
    press(2);
    push_res("busy_ignore_7_2", 4'd3, 4'd1);
    bus.btn_num = 1'b1; bus.btn_den = 1'b1; bus.btn_calc = 1'b1;
    step();
    bus.btn_num = 1'b0; bus.btn_den = 1'b0; bus.btn_calc = 1'b0;
    step();
    press_sel(1);
    repeat (6) step();
    cur_coc = 4'd3; cur_res = 4'd1; cur_dz = 1'b0;
    snap("busy_ignored");

    // reset in the second DIV cycle
    press(2);
    step();
    rst_n = 1'b0;
    model_reset();
    snap("mid_reset");
    repeat (2) step();
    rst_n = 1'b1;
    step();
    snap("after_reset");
    set_ops(4'd14, 4'd3);
    do_div("div_14_3", 4'd4, 4'd2);

    repeat (3) step();
    done = 1'b1;
  end

endmodule
